// File: rtl/trig_prime_calc.sv
// Sine/cosine (sign + BCD digits) and primality of a 9-bit operand; PRIME_EARLY_EXIT_EN enables early prime exit.
// Latency: done in the cycle after the 23rd edge following the start edge (shorter with PRIME_EARLY_EXIT_EN).
// Backpressure: none; start is only accepted in IDLE, busy flags that a request is in flight.
module trig_prime_calc #(
    parameter int PRIME_MAX_DIV = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [8:0] number,
    output logic       busy,
    output logic       done,
    output logic       sin_sign,
    output logic [3:0] sin_d0,
    output logic [3:0] sin_d1,
    output logic [3:0] sin_d2,
    output logic [3:0] sin_d3,
    output logic       cos_sign,
    output logic [3:0] cos_d0,
    output logic [3:0] cos_d1,
    output logic [3:0] cos_d2,
    output logic       is_prime
);

    typedef enum logic [2:0] {S_IDLE, S_REDUCE, S_LOOKUP, S_PRIME, S_DONE} state_t;

    state_t     state;
    logic [8:0] n;
    logic [8:0] a;
    logic [4:0] d;
    logic [9:0] sin_mag_q;
    logic       sin_neg_q;
    logic [6:0] cos_mag_q;
    logic       cos_neg_q;

    // round(sin(k deg) * 1000) for k = 0..90
    function automatic logic [9:0] quarter_sin(input logic [6:0] k);
        logic [9:0] q;
        case (k)
            7'd0:  q = 10'd0;   7'd1:  q = 10'd17;  7'd2:  q = 10'd35;  7'd3:  q = 10'd52;
            7'd4:  q = 10'd70;  7'd5:  q = 10'd87;  7'd6:  q = 10'd105; 7'd7:  q = 10'd122;
            7'd8:  q = 10'd139; 7'd9:  q = 10'd156; 7'd10: q = 10'd174; 7'd11: q = 10'd191;
            7'd12: q = 10'd208; 7'd13: q = 10'd225; 7'd14: q = 10'd242; 7'd15: q = 10'd259;
            7'd16: q = 10'd276; 7'd17: q = 10'd292; 7'd18: q = 10'd309; 7'd19: q = 10'd326;
            7'd20: q = 10'd342; 7'd21: q = 10'd358; 7'd22: q = 10'd375; 7'd23: q = 10'd391;
            7'd24: q = 10'd407; 7'd25: q = 10'd423; 7'd26: q = 10'd438; 7'd27: q = 10'd454;
            7'd28: q = 10'd469; 7'd29: q = 10'd485; 7'd30: q = 10'd500; 7'd31: q = 10'd515;
            7'd32: q = 10'd530; 7'd33: q = 10'd545; 7'd34: q = 10'd559; 7'd35: q = 10'd574;
            7'd36: q = 10'd588; 7'd37: q = 10'd602; 7'd38: q = 10'd616; 7'd39: q = 10'd629;
            7'd40: q = 10'd643; 7'd41: q = 10'd656; 7'd42: q = 10'd669; 7'd43: q = 10'd682;
            7'd44: q = 10'd695; 7'd45: q = 10'd707; 7'd46: q = 10'd719; 7'd47: q = 10'd731;
            7'd48: q = 10'd743; 7'd49: q = 10'd755; 7'd50: q = 10'd766; 7'd51: q = 10'd777;
            7'd52: q = 10'd788; 7'd53: q = 10'd799; 7'd54: q = 10'd809; 7'd55: q = 10'd819;
            7'd56: q = 10'd829; 7'd57: q = 10'd839; 7'd58: q = 10'd848; 7'd59: q = 10'd857;
            7'd60: q = 10'd866; 7'd61: q = 10'd875; 7'd62: q = 10'd883; 7'd63: q = 10'd891;
            7'd64: q = 10'd899; 7'd65: q = 10'd906; 7'd66: q = 10'd914; 7'd67: q = 10'd921;
            7'd68: q = 10'd927; 7'd69: q = 10'd934; 7'd70: q = 10'd940; 7'd71: q = 10'd946;
            7'd72: q = 10'd951; 7'd73: q = 10'd956; 7'd74: q = 10'd961; 7'd75: q = 10'd966;
            7'd76: q = 10'd970; 7'd77: q = 10'd974; 7'd78: q = 10'd978; 7'd79: q = 10'd982;
            7'd80: q = 10'd985; 7'd81: q = 10'd988; 7'd82: q = 10'd990; 7'd83: q = 10'd993;
            7'd84: q = 10'd995; 7'd85: q = 10'd996; 7'd86: q = 10'd998; 7'd87: q = 10'd999;
            7'd88: q = 10'd999; 7'd89: q = 10'd1000; 7'd90: q = 10'd1000;
            default: q = 10'd0;
        endcase
        return q;
    endfunction

    function automatic logic [15:0] to_bcd4(input logic [9:0] v);
        logic [9:0]  r;
        logic [15:0] b;
        b[15:12] = 4'(v / 10'd1000);
        r        = v % 10'd1000;
        b[11:8]  = 4'(r / 10'd100);
        r        = r % 10'd100;
        b[7:4]   = 4'(r / 10'd10);
        b[3:0]   = 4'(r % 10'd10);
        return b;
    endfunction

    function automatic logic [11:0] to_bcd3(input logic [6:0] v);
        logic [6:0]  r;
        logic [11:0] b;
        b[11:8] = 4'(v / 7'd100);
        r       = v % 7'd100;
        b[7:4]  = 4'(r / 7'd10);
        b[3:0]  = 4'(r % 7'd10);
        return b;
    endfunction

    // Fold the reduced angle onto the quarter-wave table
    logic [6:0] sin_idx, cos_idx;
    logic       sin_neg, cos_neg;
    always_comb begin
        sin_idx = 7'd0;
        cos_idx = 7'd0;
        sin_neg = 1'b0;
        cos_neg = 1'b0;
        if (a <= 9'd90) begin
            sin_idx = 7'(a);
            cos_idx = 7'(9'd90 - a);
        end else if (a <= 9'd180) begin
            sin_idx = 7'(9'd180 - a);
            cos_idx = 7'(a - 9'd90);
            cos_neg = 1'b1;
        end else if (a <= 9'd270) begin
            sin_idx = 7'(a - 9'd180);
            cos_idx = 7'(9'd270 - a);
            sin_neg = 1'b1;
            cos_neg = 1'b1;
        end else begin
            sin_idx = 7'(9'd360 - a);
            cos_idx = 7'(a - 9'd270);
            sin_neg = 1'b1;
        end
    end

    logic [9:0]  sin_l, cos_l;
    logic [6:0]  cos_rnd;
    logic [15:0] sin_bcd;
    logic [11:0] cos_bcd;
    assign sin_l   = quarter_sin(sin_idx);
    assign cos_l   = quarter_sin(cos_idx);
    assign cos_rnd = 7'((11'(cos_l) + 11'd5) / 11'd10);
    assign sin_bcd = to_bcd4(sin_mag_q);
    assign cos_bcd = to_bcd3(cos_mag_q);

    logic [8:0] d_ext;
    logic       div_hit, last_div, finish, prime_ok, prime_result;
    assign d_ext    = {4'd0, d};
    assign div_hit  = ((n % d_ext) == 9'd0) && (d_ext < n);
    assign last_div = (d == 5'(PRIME_MAX_DIV));

`ifdef PRIME_EARLY_EXIT_EN
    // Once d*d exceeds n every possible factor pair has been covered
    logic [9:0] d_sq;
    assign d_sq     = 10'(d) * 10'(d);
    assign finish   = div_hit || (d_sq > {1'b0, n}) || last_div;
    assign prime_ok = !div_hit;
`else
    logic composite_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            composite_q <= 1'b0;
        else if (state == S_LOOKUP)
            composite_q <= 1'b0;
        else if (state == S_PRIME)
            composite_q <= composite_q | div_hit;
    end
    assign finish   = last_div;
    assign prime_ok = !(composite_q || div_hit);
`endif

    assign prime_result = (n >= 9'd2) && prime_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            n         <= 9'd0;
            a         <= 9'd0;
            d         <= 5'd0;
            sin_mag_q <= 10'd0;
            sin_neg_q <= 1'b0;
            cos_mag_q <= 7'd0;
            cos_neg_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sin_sign  <= 1'b0;
            sin_d0    <= 4'd0;
            sin_d1    <= 4'd0;
            sin_d2    <= 4'd0;
            sin_d3    <= 4'd0;
            cos_sign  <= 1'b0;
            cos_d0    <= 4'd0;
            cos_d1    <= 4'd0;
            cos_d2    <= 4'd0;
            is_prime  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n     <= number;
                        busy  <= 1'b1;
                        state <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    a     <= (n >= 9'd360) ? n - 9'd360 : n;
                    state <= S_LOOKUP;
                end
                S_LOOKUP: begin
                    sin_mag_q <= sin_l;
                    sin_neg_q <= sin_neg && (sin_l != 10'd0);
                    cos_mag_q <= cos_rnd;
                    cos_neg_q <= cos_neg && (cos_rnd != 7'd0);
                    d         <= 5'd2;
                    state     <= S_PRIME;
                end
                S_PRIME: begin
                    d <= d + 5'd1;
                    if (finish) begin
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        sin_sign <= sin_neg_q;
                        sin_d0   <= sin_bcd[15:12];
                        sin_d1   <= sin_bcd[11:8];
                        sin_d2   <= sin_bcd[7:4];
                        sin_d3   <= sin_bcd[3:0];
                        cos_sign <= cos_neg_q;
                        cos_d0   <= cos_bcd[11:8];
                        cos_d1   <= cos_bcd[7:4];
                        cos_d2   <= cos_bcd[3:0];
                        is_prime <= prime_result;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trig_prime_calc.sv
// Scoreboard bench for trig_prime_calc: expected results queued at start, checked at done.
module tb_trig_prime_calc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [8:0] number;
    logic       busy, done, sin_sign, cos_sign, is_prime;
    logic [3:0] sin_d0, sin_d1, sin_d2, sin_d3, cos_d0, cos_d1, cos_d2;

    typedef struct packed {
        logic       ss;
        logic [3:0] s0, s1, s2, s3;
        logic       cs;
        logic [3:0] c0, c1, c2;
        logic       pr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;

    trig_prime_calc dut (
        .clk(clk), .rst_n(rst_n), .start(start), .number(number),
        .busy(busy), .done(done),
        .sin_sign(sin_sign), .sin_d0(sin_d0), .sin_d1(sin_d1), .sin_d2(sin_d2), .sin_d3(sin_d3),
        .cos_sign(cos_sign), .cos_d0(cos_d0), .cos_d1(cos_d1), .cos_d2(cos_d2),
        .is_prime(is_prime)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t pack_exp(input bit sn, input int sm, input bit cn, input int cm, input bit pr);
        exp_t e;
        e.ss = sn && (sm != 0);
        e.s0 = 4'(sm / 1000);
        e.s1 = 4'((sm / 100) % 10);
        e.s2 = 4'((sm / 10) % 10);
        e.s3 = 4'(sm % 10);
        e.cs = cn && (cm != 0);
        e.c0 = 4'(cm / 100);
        e.c1 = 4'((cm / 10) % 10);
        e.c2 = 4'(cm % 10);
        e.pr = pr;
        return e;
    endfunction

    function automatic int round_r(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
    endfunction

    function automatic bit model_prime(input int v);
        bit p;
        p = (v >= 2);
        for (int k = 2; k * k <= v; k++)
            if (v % k == 0) p = 1'b0;
        return p;
    endfunction

    function automatic exp_t model(input int v);
        int  ang, s, c, sa, ca;
        real rad;
        ang = v % 360;
        rad = real'(ang) * 3.14159265358979323846 / 180.0;
        s   = round_r($sin(rad) * 1000.0);
        c   = round_r($cos(rad) * 1000.0);
        sa  = (s < 0) ? -s : s;
        ca  = (c < 0) ? -c : c;
        return pack_exp(s < 0, sa, c < 0, (ca + 5) / 10, model_prime(v));
    endfunction

    function automatic exp_t observed();
        return {sin_sign, sin_d0, sin_d1, sin_d2, sin_d3, cos_sign, cos_d0, cos_d1, cos_d2, is_prime};
    endfunction

    task automatic run_op(input int num, input exp_t e, input int glitch_at);
        int   cnt;
        exp_t want, got;
        sb.push_back(e);
        @(negedge clk);
        start  = 1'b1;
        number = 9'(num);
        @(negedge clk);
        start = 1'b0;
        cnt   = 1;
        checks++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_set n=%0d: got %b expected 1", num, busy);
        end
        while (done !== 1'b1 && cnt < 40) begin
            start = (cnt == glitch_at);
            if (cnt == glitch_at) number = 9'd17;
            @(negedge clk);
            cnt++;
        end
        start = 1'b0;
        want  = sb.pop_front();
        checks++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL done_timeout n=%0d: no done within %0d cycles", num, cnt);
            return;
        end
`ifdef PRIME_EARLY_EXIT_EN
        checks++;
        if (cnt > 24 || cnt < 4) begin
            fails++;
            $display("FAIL latency n=%0d: got %0d expected 4..24", num, cnt);
        end
`else
        checks++;
        if (cnt != 24) begin
            fails++;
            $display("FAIL latency n=%0d: got %0d expected 24", num, cnt);
        end
`endif
        checks++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL busy_at_done n=%0d: got %b expected 0", num, busy);
        end
        got = observed();
        checks++;
        if ({got.ss, got.s0, got.s1, got.s2, got.s3} !== {want.ss, want.s0, want.s1, want.s2, want.s3}) begin
            fails++;
            $display("FAIL sin n=%0d: got %b %h%h%h%h expected %b %h%h%h%h", num,
                     got.ss, got.s0, got.s1, got.s2, got.s3, want.ss, want.s0, want.s1, want.s2, want.s3);
        end
        checks++;
        if ({got.cs, got.c0, got.c1, got.c2} !== {want.cs, want.c0, want.c1, want.c2}) begin
            fails++;
            $display("FAIL cos n=%0d: got %b %h%h%h expected %b %h%h%h", num,
                     got.cs, got.c0, got.c1, got.c2, want.cs, want.c0, want.c1, want.c2);
        end
        checks++;
        if (got.pr !== want.pr) begin
            fails++;
            $display("FAIL prime n=%0d: got %b expected %b", num, got.pr, want.pr);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL done_pulse n=%0d: done still %b one cycle later, expected 0", num, done);
        end
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        start  = 1'b0;
        number = 9'd0;
        repeat (3) @(negedge clk);
        checks++;
        if (observed() !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got %h expected 0", observed());
        end
        checks++;
        if ({busy, done} !== 2'b00) begin
            fails++;
            $display("FAIL reset_flags: got busy=%b done=%b expected 0 0", busy, done);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        int vn [5] = '{64, 180, 17, 256, 91};
        bit vss[5] = '{0, 0, 0, 1, 0};
        int vsm[5] = '{899, 0, 292, 970, 1000};
        bit vcs[5] = '{0, 1, 0, 1, 1};
        int vcm[5] = '{44, 100, 96, 24, 2};
        bit vpr[5] = '{0, 0, 1, 0, 0};
        for (int i = 0; i < 5; i++)
            run_op(vn[i], pack_exp(vss[i], vsm[i], vcs[i], vcm[i], vpr[i]), 0);
    endtask

    task automatic test_prime();
        int   pn[5] = '{137, 83, 0, 1, 2};
        bit   pp[5] = '{1, 1, 0, 0, 1};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            e    = model(pn[i]);
            e.pr = pp[i];
            run_op(pn[i], e, 0);
        end
        run_op(361, model(1), 0);
    endtask

    task automatic test_boundaries();
        int bn[10] = '{90, 270, 359, 360, 450, 484, 511, 479, 3, 4};
        for (int i = 0; i < 10; i++)
            run_op(bn[i], model(bn[i]), 0);
    endtask

    task automatic test_start_ignored();
        int   pulses;
        exp_t e;
        e = model(64);
        run_op(64, e, 5);
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL start_ignored: got %0d extra done pulses expected 0", pulses);
        end
        checks++;
        if (observed() !== e) begin
            fails++;
            $display("FAIL hold_outputs: got %h expected %h", observed(), e);
        end
    endtask

    task automatic test_back_to_back();
        int v;
        for (int i = 0; i < 12; i++) begin
            v = int'($urandom_range(0, 511));
            run_op(v, model(v), 0);
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        run_op(17, model(17), 0);
        @(negedge clk);
        start  = 1'b1;
        number = 9'd64;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (observed() !== '0) begin
            fails++;
            $display("FAIL abort_outputs: got %h expected 0", observed());
        end
        checks++;
        if ({busy, done} !== 2'b00) begin
            fails++;
            $display("FAIL abort_flags: got busy=%b done=%b expected 0 0", busy, done);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            fails++;
            $display("FAIL abort_no_done: got %0d done pulses expected 0", pulses);
        end
        checks++;
        if (observed() !== '0) begin
            fails++;
            $display("FAIL abort_hold: got %h expected 0", observed());
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_prime();
        test_boundaries();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
